nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_adder_pkg.sv | 13 +
 rtl/four_bit_adder.sv | 13 +
 rtl/nibble_serial_adder.sv | 113 +++++++++++
 tb/tb_nibble_serial_adder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, default size, FSM encoding.
package nibble_adder_pkg;

  localparam int NIBBLE_W        = 4;
  localparam int NIBBLES_DEFAULT = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADD  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/four_bit_adder.sv
// Combinational 4-bit adder with carry in/out; zero latency.
// No flow control: output follows inputs.
module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] y,
  output logic       c_out
);

  assign {c_out, y} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two W-bit operands one nibble per cycle through a single 4-bit adder; result NIBBLES cycles after acceptance.
// Valid/ready on both sides: no new request while busy or while a result waits for done_ready.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_valid,
  output logic                      start_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                      c_in,
  output logic                      done_valid,
  input  logic                      done_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] y,
  output logic                      c_out,
  output logic                      busy
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       y_q, y_d;
  logic               c_out_q, c_out_d;

  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
  logic                nib_cout;

  assign nib_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

  four_bit_adder u_adder (
    .a     (nib_a),
    .b     (nib_b),
    .c_in  (carry_q),
    .y     (nib_sum),
    .c_out (nib_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    c_out_d = c_out_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          idx_d   = '0;
          y_d     = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        y_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_sum;
        carry_d = nib_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          c_out_d = nib_cout;
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // start_valid is deliberately ignored here, even alongside done_ready
        if (done_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      c_out_q <= c_out_d;
    end
  end

  assign start_ready = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_ADD);
  assign done_valid  = (state_q == ST_DONE);
  assign y           = y_q;
  assign c_out       = c_out_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: each scenario task checks its own expected values inline.
module tb_nibble_serial_adder;

  logic        clk;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        done_valid;
  logic        done_ready;
  logic [15:0] y;
  logic        c_out;
  logic        busy;

  int errors = 0;
  int checks = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .c_in        (c_in),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .y           (y),
    .c_out       (c_out),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers (no checking): called at 1 time unit after a rising edge.
  task automatic start_req(input logic [15:0] av, input logic [15:0] bv, input logic ci);
    a = av;
    b = bv;
    c_in = ci;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_done();
    done_ready = 1'b1;
    @(posedge clk);
    #1;
    done_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready: got %b want 1", start_ready); end
    checks++;
    if (done_valid !== 1'b0) begin errors++; $display("FAIL reset_done_valid: got %b want 0", done_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (y !== 16'h0000 || c_out !== 1'b0) begin errors++; $display("FAIL reset_result: got y=%h c=%b want y=0000 c=0", y, c_out); end
  endtask

  task automatic test_basic();
    int lat;
    start_req(16'h0001, 16'h0001, 1'b0);
    checks++;
    if (busy !== 1'b1 || start_ready !== 1'b0) begin errors++; $display("FAIL basic_busy: got busy=%b rdy=%b want busy=1 rdy=0", busy, start_ready); end
    wait_done(lat);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
    checks++;
    if (y !== 16'h0002 || c_out !== 1'b0) begin errors++; $display("FAIL basic_sum: got y=%h c=%b want y=0002 c=0", y, c_out); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b want 0", busy); end
    release_done();
  endtask

  task automatic test_carry_chain();
    int lat;
    start_req(16'hFFFF, 16'h0001, 1'b0);
    wait_done(lat);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL chain_latency: got %0d want 4", lat); end
    checks++;
    if (y !== 16'h0000 || c_out !== 1'b1) begin errors++; $display("FAIL chain_sum: got y=%h c=%b want y=0000 c=1", y, c_out); end
    release_done();
  endtask

  task automatic test_carry_in();
    int lat;
    start_req(16'h0F0F, 16'h00F1, 1'b1);
    wait_done(lat);
    checks++;
    if (y !== 16'h1001 || c_out !== 1'b0) begin errors++; $display("FAIL cin_sum: got y=%h c=%b want y=1001 c=0", y, c_out); end
    release_done();
  endtask

  task automatic test_backpressure();
    int lat;
    start_req(16'h8000, 16'h8000, 1'b0);
    wait_done(lat);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL bp_latency: got %0d want 4", lat); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (done_valid !== 1'b1 || y !== 16'h0000 || c_out !== 1'b1 || start_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got vld=%b y=%h c=%b rdy=%b want vld=1 y=0000 c=1 rdy=0", i, done_valid, y, c_out, start_ready);
      end
      a = 16'h0001;
      b = 16'h0001;
      start_valid = (i == 1);
      @(posedge clk);
      #1;
      start_valid = 1'b0;
    end
    // start_valid coinciding with done_ready must also be ignored
    start_valid = 1'b1;
    release_done();
    start_valid = 1'b0;
    checks++;
    if (start_ready !== 1'b1 || done_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle: got rdy=%b vld=%b busy=%b want rdy=1 vld=0 busy=0", start_ready, done_valid, busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || y !== 16'h0000 || c_out !== 1'b1) begin
      errors++;
      $display("FAIL bp_retain: got busy=%b y=%h c=%b want busy=0 y=0000 c=1", busy, y, c_out);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    start_req(16'h1234, 16'h1111, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (y !== 16'h0000 || c_out !== 1'b0 || done_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_async: got y=%h c=%b vld=%b busy=%b rdy=%b want 0000/0/0/0/1", y, c_out, done_valid, busy, start_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done_valid === 1'b1 || busy === 1'b1) seen++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles want 0", seen); end
    start_req(16'h0003, 16'h0004, 1'b0);
    wait_done(lat);
    checks++;
    if (lat != 4 || y !== 16'h0007 || c_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_next: got lat=%0d y=%h c=%b want lat=4 y=0007 c=0", lat, y, c_out);
    end
    release_done();
  endtask

  task automatic test_operand_change();
    int lat;
    start_req(16'h1234, 16'h1111, 1'b0);
    a = 16'hFFFF;
    b = 16'hFFFF;
    c_in = 1'b1;
    wait_done(lat);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL hold_latency: got %0d want 4", lat); end
    checks++;
    if (y !== 16'h2345 || c_out !== 1'b0) begin errors++; $display("FAIL hold_sum: got y=%h c=%b want y=2345 c=0", y, c_out); end
    release_done();
  endtask

  initial begin
    reset = 1'b1;
    start_valid = 1'b0;
    done_ready = 1'b0;
    a = 16'h0000;
    b = 16'h0000;
    c_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    test_basic();
    test_carry_chain();
    test_backpressure();
    test_reset_abort();
    test_operand_change();
    test_carry_in();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
